q_update_sequencer: RTL
=======================

Q_UPDATE_SEQUENCER -- requirements
Module: q_update_sequencer

Interface
REQ-001 Parameter ADDR_W, default 18, state/Q-table address width.
REQ-002 Parameter N_ACTIONS, default 9, number of action RAMs.
REQ-003 Parameter CNT_W, default 16, update counter width.
REQ-004 clock  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request one Q update; sampled only in IDLE.
REQ-007 action  input  4  action code; valid values 1..9.
REQ-008 state  input  ADDR_W  current state s, the write address.
REQ-009 next_state  input  ADDR_W  next state s', the max-Q read address.
REQ-010 ram_read_address  output  ADDR_W  shared read address to all action RAMs.
REQ-011 ram_write_address  output  ADDR_W  shared write address to all action RAMs.
REQ-012 ram_write_enable  output  N_ACTIONS  one-hot write enable; bit k-1 selects action k.
REQ-013 sel_action  output  4  latched action code to the datapath mux.
REQ-014 q_capture  output  1  datapath latches Q(s,a) from the mux this cycle.
REQ-015 max_capture  output  1  datapath latches the max-Q result this cycle.
REQ-016 busy  output  1  high while an update is in flight.
REQ-017 done  output  1  one-cycle pulse after the write completes.
REQ-018 error  output  1  one-cycle pulse when start arrives with an invalid action.
REQ-019 update_count  output  CNT_W  number of completed writes.

Function
REQ-020 The FSM SHALL have the states IDLE, RD_Q, RD_MAX, CALC, WRITE and FIN.
REQ-021 In IDLE, start=1 with action in 1..9 SHALL latch action, state and next_state and move to RD_Q.
REQ-022 In IDLE, start=1 with action 0 or 10..15 SHALL pulse error in the next cycle, stay in IDLE and latch nothing.
REQ-023 RD_Q SHALL drive ram_read_address = latched state, then move to RD_MAX.
REQ-024 RD_MAX SHALL drive ram_read_address = latched next_state, assert q_capture, then move to CALC.
REQ-025 CALC SHALL assert max_capture, then move to WRITE.
REQ-026 WRITE SHALL drive ram_write_address = latched state and assert exactly the one ram_write_enable bit for the latched action, then move to FIN.
REQ-027 FIN SHALL assert done for one cycle and return to IDLE.
REQ-028 busy SHALL be 1 in RD_Q, RD_MAX, CALC and WRITE, and 0 in IDLE and FIN.
REQ-029 Latency SHALL be fixed: start sampled in cycle 0 gives the write in cycle 4 and done in cycle 5.
REQ-030 Throughput SHALL be one update per 5 cycles; start in cycle 5 (IDLE again) SHALL be accepted.
REQ-031 start while not in IDLE SHALL be ignored, with no queuing and no error.
REQ-032 Input changes after acceptance SHALL NOT affect the in-flight update.
REQ-033 state == next_state SHALL be legal; both reads precede the write, so no hazard exists.
REQ-034 ram_write_enable SHALL be all-zero outside WRITE.
REQ-035 ram_read_address SHALL hold its last value outside RD_Q and RD_MAX.
REQ-036 update_count SHALL increment by 1 in the cycle after WRITE and saturate at all-ones.
REQ-037 sel_action SHALL present the latched action from RD_Q through WRITE.

Reset
REQ-038 reset=1 SHALL force IDLE, latched registers to 0, all address outputs to 0, ram_write_enable to 0, all pulse outputs and busy to 0, and update_count to 0.
REQ-039 reset asserted mid-update, including in WRITE, SHALL suppress the write in that cycle and produce no done.
REQ-040 reset SHALL take priority over start in the same cycle.

Structure
REQ-041 The FSM state encoding, N_ACTIONS, ADDR_W and the valid action range SHALL live in the shared package q_learning_pkg.
REQ-042 One sub-module, action_onehot, SHALL map the 4-bit action to an N_ACTIONS one-hot vector plus a valid flag; the FSM gates its output with WRITE.
REQ-043 All outputs SHALL be registered, except ram_write_enable, which is decode AND state.

Verification
REQ-044 reset, then start with action=3, state=0x00012, next_state=0x00034 -> read addresses 0x00012 then 0x00034 in cycles 1 and 2, ram_write_enable=9'b000000100 at address 0x00012 in cycle 4, done in cycle 5, update_count=1.
REQ-045 start with action=0, then action=12 -> error pulses each time, busy stays 0, no write, update_count unchanged.
REQ-046 start held high for 12 cycles with action=9 -> exactly 2 writes (cycles 4 and 9) with ram_write_enable=9'b100000000, and 2 done pulses.
REQ-047 reset asserted during WRITE -> ram_write_enable=0 that cycle, no done, FSM in IDLE the next cycle.
REQ-048 With CNT_W=4, 17 valid updates -> update_count saturates at 4'hF.
REQ-049 action changes from 5 to 7 during RD_MAX -> write still on bit 4 (action 5).

Source files
------------

// File: rtl/q_learning_pkg.sv
// Shared definitions for the Q-learning update path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package q_learning_pkg;
   localparam int Q_ADDR_W    = 18;
   localparam int Q_N_ACTIONS = 9;
   localparam int ACTION_W    = 4;
   localparam int ACTION_MIN  = 1;
   localparam int ACTION_MAX  = 9;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD_Q   = 3'd1,
      S_RD_MAX = 3'd2,
      S_CALC   = 3'd3,
      S_WRITE  = 3'd4,
      S_FIN    = 3'd5
   } fsm_state_t;
endpackage

// File: rtl/action_onehot.sv
// Decodes a 4-bit action code into a one-hot RAM select plus a valid flag.
// Latency: combinational.
// Backpressure: none; pure decode.
module action_onehot
   import q_learning_pkg::*;
#(
   parameter int N_OUT = Q_N_ACTIONS
) (
   input  logic [ACTION_W-1:0] action,
   output logic [N_OUT-1:0]    onehot,
   output logic                valid
);

   // bit k-1 selects action k; out-of-range codes decode to all-zero
   always_comb begin
      onehot = '0;
      valid  = (int'(action) >= ACTION_MIN) && (int'(action) <= ACTION_MAX)
               && (int'(action) <= N_OUT);
      for (int k = 0; k < N_OUT; k++) begin
         onehot[k] = valid && (int'(action) == k + 1);
      end
   end

endmodule

// File: rtl/q_update_sequencer.sv
// Sequences one Q-table update: read Q(s,a), read max-Q(s'), compute, write back.
// Latency: write 4 cycles after the accepting edge, done pulse 1 cycle later.
// Backpressure: start ignored while busy (no queue); FIN accepts the next start.
module q_update_sequencer
   import q_learning_pkg::*;
#(
   parameter int ADDR_W    = Q_ADDR_W,
   parameter int N_ACTIONS = Q_N_ACTIONS,
   parameter int CNT_W     = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ACTION_W-1:0]  action,
   input  logic [ADDR_W-1:0]    state,
   input  logic [ADDR_W-1:0]    next_state,
   output logic [ADDR_W-1:0]    ram_read_address,
   output logic [ADDR_W-1:0]    ram_write_address,
   output logic [N_ACTIONS-1:0] ram_write_enable,
   output logic [ACTION_W-1:0]  sel_action,
   output logic                 q_capture,
   output logic                 max_capture,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [CNT_W-1:0]     update_count
);

   fsm_state_t           fsm_cur;
   fsm_state_t           fsm_nxt;
   logic [N_ACTIONS-1:0] dec_onehot;
   logic                 dec_valid;
   logic [N_ACTIONS-1:0] wen_latched;
   logic [ADDR_W-1:0]    next_latched;
   logic                 accept;
   logic                 reject;

   // decode the live action so the valid check and one-hot are ready at acceptance
   action_onehot #(.N_OUT(N_ACTIONS)) u_decode (
      .action (action),
      .onehot (dec_onehot),
      .valid  (dec_valid)
   );

   // state register
   always_ff @(posedge clock) begin
      if (reset) fsm_cur <= S_IDLE;
      else       fsm_cur <= fsm_nxt;
   end

   // next-state and accept/reject; FIN doubles as the idle slot so updates run every 5 cycles
   always_comb begin
      fsm_nxt = fsm_cur;
      accept  = 1'b0;
      reject  = 1'b0;
      case (fsm_cur)
         S_IDLE, S_FIN: begin
            fsm_nxt = S_IDLE;
            if (start) begin
               if (dec_valid) begin
                  accept  = 1'b1;
                  fsm_nxt = S_RD_Q;
               end else begin
                  reject  = 1'b1;
               end
            end
         end
         S_RD_Q:   fsm_nxt = S_RD_MAX;
         S_RD_MAX: fsm_nxt = S_CALC;
         S_CALC:   fsm_nxt = S_WRITE;
         S_WRITE:  fsm_nxt = S_FIN;
         default:  fsm_nxt = S_IDLE;
      endcase
   end

   // registered outputs are computed from the next state so they line up with it
   always_ff @(posedge clock) begin
      if (reset) begin
         ram_read_address  <= '0;
         ram_write_address <= '0;
         next_latched      <= '0;
         wen_latched       <= '0;
         sel_action        <= '0;
         q_capture         <= 1'b0;
         max_capture       <= 1'b0;
         busy              <= 1'b0;
         done              <= 1'b0;
         error             <= 1'b0;
         update_count      <= '0;
      end else begin
         q_capture   <= (fsm_nxt == S_RD_MAX);
         max_capture <= (fsm_nxt == S_CALC);
         done        <= (fsm_nxt == S_FIN);
         busy        <= (fsm_nxt inside {S_RD_Q, S_RD_MAX, S_CALC, S_WRITE});
         error       <= reject;
         if (accept) begin
            ram_write_address <= state;
            ram_read_address  <= state;
            next_latched      <= next_state;
            wen_latched       <= dec_onehot;
            sel_action        <= action;
         end else if (fsm_cur == S_RD_Q) begin
            ram_read_address  <= next_latched;
         end
         if (fsm_cur == S_WRITE && update_count != '1) begin
            update_count <= update_count + CNT_W'(1);
         end
      end
   end

   // write strobe is the only unregistered output; reset kills it in the same cycle
   assign ram_write_enable = (fsm_cur == S_WRITE && !reset) ? wen_latched : '0;

endmodule
